// File: rtl/sort_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
//
// Purpose
//   Shared constants for the four-input pipelined sorter and the min/max
//   compare unit it is built from.
//
// Contents
//   c_nstages        number of registered stages in the sorting pipeline
//   c_nelems         number of elements in one set
//   c_nbits_default  default element width
//
// The per-set type (c_nelems elements of p_nbits each) depends on a module
// parameter. A package cannot carry that parameter, so each module that
// needs the type declares it locally from these constants.
// ----------------------------------------------------------------------------
package sort_pkg;

    // Three register stages: one per column of the 5-comparator network.
    localparam int c_nstages = 3;

    // Elements per set.
    localparam int c_nelems = 4;

    // Default element width.
    localparam int c_nbits_default = 8;

endpackage : sort_pkg

// File: rtl/tut3_verilog_sort_MinMaxUnit.sv
// ----------------------------------------------------------------------------
// tut3_verilog_sort_MinMaxUnit
//
// Purpose
//   Purely combinational unsigned compare-and-swap. This is the single
//   comparator element from which the sorting network is assembled.
//
// Parameters
//   p_nbits   element width (unsigned)
//
// Ports
//   in0      in   p_nbits  first operand
//   in1      in   p_nbits  second operand
//   out_min  out  p_nbits  smaller of the two operands
//   out_max  out  p_nbits  larger of the two operands
//
// On a tie (in0 == in1) in0 is routed to out_max. Both outputs then carry
// the same value, so the choice does not affect a downstream sort.
// ----------------------------------------------------------------------------
module tut3_verilog_sort_MinMaxUnit
    import sort_pkg::*;
#(
    parameter int p_nbits = c_nbits_default
)
(
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] out_min,
    output logic [p_nbits-1:0] out_max
);

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via defaults first); a missed path infers a latch.
        out_min = in1;
        out_max = in0;
        if (in0 < in1) begin
            out_min = in0;
            out_max = in1;
        end
    end

endmodule : tut3_verilog_sort_MinMaxUnit

// File: rtl/sort_unit_pipe_valrdy.sv
// ----------------------------------------------------------------------------
// sort_unit_pipe_valrdy
//
// Purpose
//   Four-input unsigned sorter. A 5-comparator sorting network built from
//   tut3_verilog_sort_MinMaxUnit instances, split into three registered
//   stages with val/rdy handshakes on both sides. It sustains one set per
//   cycle. Backpressure collapses bubbles: an empty stage still fills while a
//   downstream stage is stalled.
//
//   Network (pos i <- min, pos j <- max):
//     stage 1 : (0,1) (2,3)
//     stage 2 : (0,2) (1,3)
//     stage 3 : (1,2)
//
// Parameters
//   p_nbits   element width (unsigned)
//
// Ports
//   clk       in   1        clock, rising edge
//   reset     in   1        asynchronous, active-high; clears all state
//   in_val    in   1        input set valid
//   in_rdy    out  1        block accepts an input set this cycle
//   in0..in3  in   p_nbits  unsorted elements
//   out_val   out  1        sorted set valid
//   out_rdy   in   1        consumer accepts the sorted set this cycle
//   out0..3   out  p_nbits  sorted elements, out0 <= out1 <= out2 <= out3
//   busy      out  1        at least one stage holds a valid set
// ----------------------------------------------------------------------------
module sort_unit_pipe_valrdy
    import sort_pkg::*;
#(
    parameter int p_nbits = c_nbits_default
)
(
    input  logic               clk,
    input  logic               reset,

    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,

    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out0,
    output logic [p_nbits-1:0] out1,
    output logic [p_nbits-1:0] out2,
    output logic [p_nbits-1:0] out3,

    output logic               busy
);

    // One set of elements; index 0 is the smallest position once sorted.
    typedef logic [c_nelems-1:0][p_nbits-1:0] elem_set_t;

    // ------------------------------------------------------------------
    // Pipeline state
    //   vld[k] is the valid bit of stage k+1 (v1, v2, v3).
    //   r1..r3 hold the set that leaves each stage.
    // ------------------------------------------------------------------
    logic [c_nstages-1:0] vld;
    elem_set_t            r1;
    elem_set_t            r2;
    elem_set_t            r3;

    // Combinational network outputs feeding each register.
    elem_set_t            s1;
    elem_set_t            s2;
    elem_set_t            s3;

    // Handshake/advance strobes.
    logic                 adv3;   // stage 3 hands its set to the consumer
    logic                 go3;    // stage 2 -> stage 3 transfer
    logic                 go2;    // stage 1 -> stage 2 transfer
    logic                 go1;    // input   -> stage 1 transfer

    // ------------------------------------------------------------------
    // Stage 1 network: (0,1) (2,3) on the raw inputs.
    // ------------------------------------------------------------------
    tut3_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_s1_01 (
        .in0     (in0),
        .in1     (in1),
        .out_min (s1[0]),
        .out_max (s1[1])
    );

    tut3_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_s1_23 (
        .in0     (in2),
        .in1     (in3),
        .out_min (s1[2]),
        .out_max (s1[3])
    );

    // ------------------------------------------------------------------
    // Stage 2 network: (0,2) (1,3). Afterwards pos 0 holds the global
    // minimum and pos 3 the global maximum.
    // ------------------------------------------------------------------
    tut3_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_s2_02 (
        .in0     (r1[0]),
        .in1     (r1[2]),
        .out_min (s2[0]),
        .out_max (s2[2])
    );

    tut3_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_s2_13 (
        .in0     (r1[1]),
        .in1     (r1[3]),
        .out_min (s2[1]),
        .out_max (s2[3])
    );

    // ------------------------------------------------------------------
    // Stage 3 network: (1,2) settles the middle pair; the ends are
    // already final and pass straight through.
    // ------------------------------------------------------------------
    tut3_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_s3_12 (
        .in0     (r2[1]),
        .in1     (r2[2]),
        .out_min (s3[1]),
        .out_max (s3[2])
    );

    assign s3[0] = r2[0];
    assign s3[3] = r2[3];

    // ------------------------------------------------------------------
    // Flow control. The chain runs from out_rdy back to in_rdy, so a full
    // pipe still accepts in the cycle it emits. in_val enters only go1,
    // never in_rdy, which keeps the handshake free of combinational loops
    // through an upstream block.
    // ------------------------------------------------------------------
    always_comb begin
        adv3   = 1'b0;
        go3    = 1'b0;
        go2    = 1'b0;
        in_rdy = 1'b0;
        go1    = 1'b0;

        adv3   = vld[2] & out_rdy;
        go3    = vld[1] & (~vld[2] | adv3);
        go2    = vld[0] & (~vld[1] | go3);
        in_rdy = ~vld[0] | go2;
        go1    = in_val & in_rdy;
    end

    // ------------------------------------------------------------------
    // Valid bits. A stage is occupied next cycle if it is loaded now, or
    // if it already holds a set that is not moving on.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else begin
            // NOTE: flops are written with <= so every stage samples the
            // pre-edge value of its neighbour; = here would shift a set
            // through several stages in one clock.
            vld[0] <= go1 | (vld[0] & ~go2);
            vld[1] <= go2 | (vld[1] & ~go3);
            vld[2] <= go3 | (vld[2] & ~adv3);
        end
    end

    // ------------------------------------------------------------------
    // Data registers. Each loads only on its own go strobe and otherwise
    // holds, which keeps out0..out3 stable while the consumer stalls and
    // keeps X/Z on idle input lanes out of the pipeline.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data registers are cleared as well as the valid
            // bits so the outputs read 0 out of reset instead of stale data.
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else begin
            if (go1) begin
                r1 <= s1;
            end
            if (go2) begin
                r2 <= s2;
            end
            if (go3) begin
                r3 <= s3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_val = vld[2];
    assign out0    = r3[0];
    assign out1    = r3[1];
    assign out2    = r3[2];
    assign out3    = r3[3];
    assign busy    = |vld;

endmodule : sort_unit_pipe_valrdy

// File: tb/tb_sort_unit_pipe_valrdy.sv
// ----------------------------------------------------------------------------
// tb_sort_unit_pipe_valrdy
//
// Directed bench for the four-input pipelined sorter. Inputs change and
// outputs are sampled just after the falling edge. State updates happen on
// the rising edge. Accepted sets queue their expected sorted result, and
// every emitted set is compared against the head of that queue.
// Set values are packed as {out0,out1,out2,out3}, so the hex reads smallest
// first.
// ----------------------------------------------------------------------------
module tb_sort_unit_pipe_valrdy;

    localparam int p_nbits = 8;

    logic               clk;
    logic               reset;
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in0, in1, in2, in3;
    logic               out_val;
    logic               out_rdy;
    logic [p_nbits-1:0] out0, out1, out2, out3;
    logic               busy;

    int                 total;
    int                 bad;
    int                 sent;
    int                 rcvd;
    logic [31:0]        cur_exp;
    logic [31:0]        exp_q [$];

    sort_unit_pipe_valrdy #(.p_nbits(p_nbits)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] out_set();
        return {out0, out1, out2, out3};
    endfunction

    // Reference sort: plain bubble sort of four values.
    function automatic logic [31:0] sort4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        logic [7:0] e [4];
        logic [7:0] t;
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3 - i; j++) begin
                if (e[j] > e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
            end
        end
        return {e[0], e[1], e[2], e[3]};
    endfunction

    // Random element biased toward the extremes 0 and 255.
    function automatic logic [7:0] relem();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'hff;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic set_in(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [31:0] expv);
        in_val  = v;
        in0     = a;
        in1     = b;
        in2     = c;
        in3     = d;
        cur_exp = expv;
    endtask

    task automatic set_rand(input logic v);
        logic [7:0] a, b, c, d;
        a = relem(); b = relem(); c = relem(); d = relem();
        set_in(v, a, b, c, d, sort4(a, b, c, d));
    endtask

    task automatic settle();
        #1;
    endtask

    // Observe one cycle: score any output transfer, record any input
    // transfer, then move on to the next falling edge.
    task automatic tick();
        #1;
        if (out_val === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_val", 32'(out_val), 0);
            end else begin
                check("out_data", out_set(), exp_q.pop_front());
            end
            rcvd++;
        end
        if (in_val === 1'b1 && in_rdy === 1'b1) begin
            exp_q.push_back(cur_exp);
            sent++;
        end
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int base_sent;
        int budget;

        total   = 0;
        bad     = 0;
        sent    = 0;
        rcvd    = 0;
        reset   = 1'b1;
        out_rdy = 1'b0;
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);

        // ---- reset state
        @(negedge clk);
        settle();
        check("rst_out_val", 32'(out_val), 0);
        check("rst_busy",    32'(busy),    0);
        check("rst_in_rdy",  32'(in_rdy),  1);
        check("rst_out_data", out_set(), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // ---- 1: single set, latency 3, busy clears after the output leaves
        out_rdy = 1'b1;
        set_in(1'b1, 8'd4, 8'd3, 8'd2, 8'd1, 32'h01020304);
        settle();
        check("t1_in_rdy", 32'(in_rdy), 1);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
        settle();
        check("t1_lat_e1", 32'(out_val), 0);
        tick();
        check("t1_lat_e2", 32'(out_val), 0);
        tick();
        check("t1_lat_e3_val",  32'(out_val), 1);
        check("t1_lat_e3_busy", 32'(busy),    1);
        check("t1_lat_e3_data", out_set(), 32'h01020304);
        tick();
        check("t1_after_val",  32'(out_val), 0);
        check("t1_after_busy", 32'(busy),    0);

        // ---- 2: ten back-to-back random sets, out_rdy held high
        for (int i = 0; i < 13; i++) begin
            if (i < 10) set_rand(1'b1);
            else        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
            settle();
            check("t2_in_rdy",  32'(in_rdy),  1);
            check("t2_out_val", 32'(out_val), (i >= 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("t2_queue_empty", 32'(exp_q.size()), 0);

        // ---- 3: stall with three sets in flight, then drain in order
        out_rdy = 1'b0;
        set_in(1'b1, 8'd9,   8'd0, 8'd5, 8'd5, 32'h00050509);
        settle(); check("t3_in_rdy_a", 32'(in_rdy), 1); tick();
        set_in(1'b1, 8'd255, 8'd1, 8'd1, 8'd0, 32'h000101ff);
        settle(); check("t3_in_rdy_b", 32'(in_rdy), 1); tick();
        set_in(1'b1, 8'd7,   8'd7, 8'd7, 8'd7, 32'h07070707);
        settle(); check("t3_in_rdy_c", 32'(in_rdy), 1); tick();
        // A fourth set is offered but must be refused while full.
        set_in(1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 32'h01010101);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_full_in_rdy",  32'(in_rdy),  0);
            check("t3_stall_val",    32'(out_val), 1);
            check("t3_stall_data",   out_set(), 32'h00050509);
            tick();
        end
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_drain_val", 32'(out_val), 1);
            tick();
        end
        check("t3_drained_val", 32'(out_val), 0);
        check("t3_queue_empty", 32'(exp_q.size()), 0);

        // ---- 4: full pipe accepts and emits in the same cycle
        out_rdy = 1'b0;
        set_in(1'b1, 8'd8, 8'd6,   8'd7, 8'd5,   32'h05060708); tick();
        set_in(1'b1, 8'd0, 8'd255, 8'd0, 8'd255, 32'h0000ffff); tick();
        set_in(1'b1, 8'd3, 8'd1,   8'd2, 8'd3,   32'h01020303); tick();
        set_in(1'b1, 8'd200, 8'd100, 8'd150, 8'd50, 32'h326496c8);
        out_rdy = 1'b1;
        settle();
        check("t4_in_rdy_full",  32'(in_rdy),  1);
        check("t4_out_val_full", 32'(out_val), 1);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
        out_rdy = 1'b0;
        settle();
        check("t4_still_full", 32'(in_rdy), 0);
        check("t4_busy",       32'(busy),   1);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t4_drained_val", 32'(out_val), 0);
        check("t4_queue_empty", 32'(exp_q.size()), 0);

        // ---- 5: random valid/ready over 500 sets
        base_sent = sent;
        budget    = 0;
        while ((sent - base_sent) < 500 && budget < 5000) begin
            set_rand(1'($urandom_range(0, 1)));
            out_rdy = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        check("t5_sent", 32'(sent - base_sent), 500);
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            out_rdy = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        check("t5_queue_empty", 32'(exp_q.size()), 0);
        check("t5_rcvd_eq_sent", 32'(rcvd), 32'(sent));
        out_rdy = 1'b1;
        settle();
        check("t5_idle_val", 32'(out_val), 0);

        // ---- 6: asynchronous reset with two sets in flight
        out_rdy = 1'b0;
        set_in(1'b1, 8'd100, 8'd50, 8'd75, 8'd25, 32'h19324b64); tick();
        set_in(1'b1, 8'd3,   8'd3,  8'd0,  8'd0,  32'h00000303); tick();
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);         tick();
        settle();
        check("t6_pre_val", 32'(out_val), 1);
        reset = 1'b1;
        #1;
        check("t6_rst_val",    32'(out_val), 0);
        check("t6_rst_busy",   32'(busy),    0);
        check("t6_rst_in_rdy", 32'(in_rdy),  1);
        check("t6_rst_data",   out_set(), 32'h0);
        exp_q.delete();
        @(negedge clk);
        reset   = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t6_no_emit", 32'(out_val), 0);
            tick();
        end
        set_in(1'b1, 8'd10, 8'd40, 8'd30, 8'd20, 32'h0a141e28);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
        settle(); check("t6_lat_e1", 32'(out_val), 0); tick();
        check("t6_lat_e2", 32'(out_val), 0); tick();
        check("t6_lat_e3", 32'(out_val), 1);
        tick();
        check("t6_queue_empty", 32'(exp_q.size()), 0);
        check("t6_final_busy",  32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sort_unit_pipe_valrdy
